// File: rtl/wb_stage_buf.sv
// Buffered writeback stage: MEM/WB results go into a DEPTH-entry in-order FIFO and drain to the register-file write port.
// Latency 1 cycle from accept to head; the head outputs and wb_reg_write come straight from registers.
// Backpressure: in_ready = occupancy < DEPTH (no same-cycle pass-through); the head holds until wb_write_ready grants it.
// Optional macro WB_RETIRE_CNT_EN adds the wb_retire_cnt output (a count of retired entries).
module wb_stage_buf #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_wb_ctl,
  input  logic [DATA_W-1:0]        in_alu_result,
  input  logic [DATA_W-1:0]        in_read_data,
  input  logic [DATA_W-1:0]        in_link_addr,
  input  logic [1:0]               in_mem_size,
  input  logic                     in_mem_unsigned,
  input  logic [1:0]               in_addr_lo,
  input  logic [REG_AW-1:0]        in_reg_dst,
  output logic [DATA_W-1:0]        wb_write_data,
  output logic [REG_AW-1:0]        wb_write_reg,
  output logic                     wb_reg_write,
  input  logic                     wb_write_ready,
  output logic                     wb_retire,
  output logic [$clog2(DEPTH):0]   wb_count
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]         wb_retire_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Load extraction hard-codes 32-bit lanes; the FIFO relies on power-of-two pointer wrap.
  if (DATA_W != 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_check
    $error("wb_stage_buf: unsupported parameter set");
  end

  // Each entry carries the already-selected result, so the drain side is a plain register-file write.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] dst;
    logic              wen;
  } wb_ent_t;

  wb_ent_t           r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_wb_data;
  logic [REG_AW-1:0] r_wb_reg;
  logic              r_reg_write;
  logic              r_retire;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  wb_ent_t           w_push_ent;
  wb_ent_t           w_next_head;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_count_nxt;
  logic [PW-1:0]     w_rptr_nxt;
  logic              w_head_load;

  // Byte/halfword lane select and sign/zero extension of the raw memory word (little-endian).
  always_comb begin
    w_byte = 8'h00;
    case (in_addr_lo)
      2'd0:    w_byte = in_read_data[7:0];
      2'd1:    w_byte = in_read_data[15:8];
      2'd2:    w_byte = in_read_data[23:16];
      default: w_byte = in_read_data[31:24];
    endcase
    // Misaligned halfwords are not trapped; bit 0 of the address is simply ignored.
    w_half = in_addr_lo[1] ? in_read_data[31:16] : in_read_data[15:0];
    case (in_mem_size)
      2'b00:   w_load = {{(DATA_W-8){~in_mem_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{(DATA_W-16){~in_mem_unsigned & w_half[15]}}, w_half};
      default: w_load = in_read_data;
    endcase
  end

  // Source mux and effective write flag, resolved before the entry is stored.
  always_comb begin
    w_push_ent = '0;
    case (in_wb_ctl[2:1])
      2'b01:   w_push_ent.data = w_load;
      2'b10:   w_push_ent.data = in_link_addr;
      default: w_push_ent.data = in_alu_result;
    endcase
    w_push_ent.dst = in_reg_dst;
    // r0 is hard-wired to zero, so a write to it retires without touching the port.
    w_push_ent.wen = in_wb_ctl[0] & (in_reg_dst != '0);
  end

  assign in_ready = (r_count < CW'(DEPTH));
  assign w_push   = in_valid & in_ready;
  // A non-writing head leaves after one cycle; a writing head waits for the port grant.
  assign w_pop    = (r_count != '0) & (~r_reg_write | wb_write_ready);

  // Next occupancy, next read pointer and the entry that will sit at the head next cycle.
  always_comb begin
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    w_rptr_nxt  = w_pop ? r_rptr + PW'(1) : r_rptr;
    w_head_load = (w_count_nxt != '0);
    // The incoming entry becomes the head when the FIFO is (or is about to be) otherwise empty.
    if (r_count == '0 || (r_count == CW'(1) && w_pop)) begin
      w_next_head = w_push_ent;
    end else begin
      w_next_head = r_mem[w_rptr_nxt];
    end
  end

  // Entry storage; contents are only meaningful between read and write pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_ent;
    end
  end

  // Pointers, occupancy and the registered head/write-port outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_wb_data   <= '0;
      r_wb_reg    <= '0;
      r_reg_write <= 1'b0;
      r_retire    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      r_rptr      <= w_rptr_nxt;
      r_count     <= w_count_nxt;
      r_retire    <= w_pop;
      r_reg_write <= w_head_load & w_next_head.wen;
      // When the FIFO drains, data and register address keep their last values.
      if (w_head_load) begin
        r_wb_data <= w_next_head.data;
        r_wb_reg  <= w_next_head.dst;
      end
    end
  end

  assign wb_write_data = r_wb_data;
  assign wb_write_reg  = r_wb_reg;
  assign wb_reg_write  = r_reg_write;
  assign wb_retire     = r_retire;
  assign wb_count      = r_count;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retire_cnt;

  // Retired-entry counter; advances on the same edge that raises wb_retire, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retire_cnt <= '0;
    end else if (w_pop) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign wb_retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
// Directed bench for wb_stage_buf: table of single-entry vectors plus stall, streaming and reset sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge, half a cycle after the rising edge.
// Prints one FAIL line per bad comparison and a single summary line at the end.
module tb_wb_stage_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_wb_ctl;
  logic [31:0] in_alu_result;
  logic [31:0] in_read_data;
  logic [31:0] in_link_addr;
  logic [1:0]  in_mem_size;
  logic        in_mem_unsigned;
  logic [1:0]  in_addr_lo;
  logic [4:0]  in_reg_dst;
  logic [31:0] wb_write_data;
  logic [4:0]  wb_write_reg;
  logic        wb_reg_write;
  logic        wb_write_ready;
  logic        wb_retire;
  logic [1:0]  wb_count;
`ifdef WB_RETIRE_CNT_EN
  logic [15:0] wb_retire_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_stage_buf #(.DATA_W(32), .REG_AW(5), .DEPTH(2), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_wb_ctl       (in_wb_ctl),
    .in_alu_result   (in_alu_result),
    .in_read_data    (in_read_data),
    .in_link_addr    (in_link_addr),
    .in_mem_size     (in_mem_size),
    .in_mem_unsigned (in_mem_unsigned),
    .in_addr_lo      (in_addr_lo),
    .in_reg_dst      (in_reg_dst),
    .wb_write_data   (wb_write_data),
    .wb_write_reg    (wb_write_reg),
    .wb_reg_write    (wb_reg_write),
    .wb_write_ready  (wb_write_ready),
    .wb_retire       (wb_retire),
    .wb_count        (wb_count)
`ifdef WB_RETIRE_CNT_EN
    ,
    .wb_retire_cnt   (wb_retire_cnt)
`endif
  );

  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] link;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lo;
    logic [4:0]  dst;
    logic        exp_wen;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid        = 1'b1;
    in_wb_ctl       = v.ctl;
    in_alu_result   = v.alu;
    in_read_data    = v.rd;
    in_link_addr    = v.link;
    in_mem_size     = v.size;
    in_mem_unsigned = v.uns;
    in_addr_lo      = v.lo;
    in_reg_dst      = v.dst;
  endtask

  // ALU-sourced writing entry with given data and destination.
  function automatic vec_t alu_vec(input logic [31:0] d, input logic [4:0] r);
    vec_t v;
    v = '{3'b001, d, 32'h0, 32'h0, 2'b10, 1'b0, 2'd0, r, 1'b1, d};
    return v;
  endfunction

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_wb_ctl = '0; in_alu_result = '0; in_read_data = '0;
    in_link_addr = '0; in_mem_size = '0; in_mem_unsigned = 1'b0; in_addr_lo = '0;
    in_reg_dst = '0; wb_write_ready = 1'b0;

    //         ctl     alu           rd            link          sz     uns   lo    dst  wen   expected data
    vecs[0]  = '{3'b001, 32'h12345678, 32'h0,        32'h11111111, 2'b00, 1'b0, 2'd0, 5'd5,  1'b1, 32'h12345678};
    vecs[1]  = '{3'b011, 32'hA5A5A5A5, 32'h80FF7F01, 32'h11111111, 2'b00, 1'b0, 2'd2, 5'd6,  1'b1, 32'hFFFFFFFF};
    vecs[2]  = '{3'b011, 32'hA5A5A5A5, 32'h80FF7F01, 32'h11111111, 2'b00, 1'b1, 2'd2, 5'd6,  1'b1, 32'h000000FF};
    vecs[3]  = '{3'b011, 32'hA5A5A5A5, 32'h80FF7F01, 32'h11111111, 2'b01, 1'b0, 2'd2, 5'd7,  1'b1, 32'hFFFF80FF};
    vecs[4]  = '{3'b011, 32'hA5A5A5A5, 32'h80FF7F01, 32'h11111111, 2'b01, 1'b1, 2'd3, 5'd7,  1'b1, 32'h000080FF};
    vecs[5]  = '{3'b011, 32'hA5A5A5A5, 32'h80FF7F01, 32'h11111111, 2'b00, 1'b0, 2'd0, 5'd8,  1'b1, 32'h00000001};
    vecs[6]  = '{3'b011, 32'hA5A5A5A5, 32'h80FF7F01, 32'h11111111, 2'b00, 1'b0, 2'd1, 5'd8,  1'b1, 32'h0000007F};
    vecs[7]  = '{3'b011, 32'hA5A5A5A5, 32'h80FF7F01, 32'h11111111, 2'b00, 1'b0, 2'd3, 5'd8,  1'b1, 32'hFFFFFF80};
    vecs[8]  = '{3'b011, 32'hA5A5A5A5, 32'h80FF7F01, 32'h11111111, 2'b01, 1'b0, 2'd1, 5'd9,  1'b1, 32'h00007F01};
    vecs[9]  = '{3'b011, 32'hA5A5A5A5, 32'h80FF7F01, 32'h11111111, 2'b10, 1'b0, 2'd2, 5'd10, 1'b1, 32'h80FF7F01};
    vecs[10] = '{3'b011, 32'hA5A5A5A5, 32'h80FF7F01, 32'h11111111, 2'b11, 1'b1, 2'd1, 5'd10, 1'b1, 32'h80FF7F01};
    vecs[11] = '{3'b101, 32'hA5A5A5A5, 32'h80FF7F01, 32'h00400008, 2'b00, 1'b0, 2'd0, 5'd31, 1'b1, 32'h00400008};
    vecs[12] = '{3'b111, 32'hDEADBEEF, 32'h80FF7F01, 32'h00400008, 2'b00, 1'b0, 2'd0, 5'd12, 1'b1, 32'hDEADBEEF};
    vecs[13] = '{3'b000, 32'hCAFEF00D, 32'h0,        32'h0,        2'b10, 1'b0, 2'd0, 5'd5,  1'b0, 32'h0};
    vecs[14] = '{3'b001, 32'hCAFEF00D, 32'h0,        32'h0,        2'b10, 1'b0, 2'd0, 5'd0,  1'b0, 32'h0};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_reg_write", 32'(wb_reg_write), 32'd0);
    check("rst_data", wb_write_data, 32'h0);
    check("rst_reg", 32'(wb_write_reg), 32'd0);
    check("rst_retire", 32'(wb_retire), 32'd0);
    check("rst_count", 32'(wb_count), 32'd0);
`ifdef WB_RETIRE_CNT_EN
    check("rst_retire_cnt", 32'(wb_retire_cnt), 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single entries, port always granting
    wb_write_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_reg_write", i), 32'(wb_reg_write), 32'(vecs[i].exp_wen));
      check($sformatf("v%0d_count", i), 32'(wb_count), 32'd1);
      check($sformatf("v%0d_retire_early", i), 32'(wb_retire), 32'd0);
      if (vecs[i].exp_wen) begin
        check($sformatf("v%0d_data", i), wb_write_data, vecs[i].exp_data);
        check($sformatf("v%0d_reg", i), 32'(wb_write_reg), 32'(vecs[i].dst));
      end
      @(negedge clk);
      check($sformatf("v%0d_retire", i), 32'(wb_retire), 32'd1);
      check($sformatf("v%0d_count_after", i), 32'(wb_count), 32'd0);
      check($sformatf("v%0d_reg_write_after", i), 32'(wb_reg_write), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_retire_once", i), 32'(wb_retire), 32'd0);
    end

    // Stall: port busy, three pushes against two entries
    wb_write_ready = 1'b0;
    drive(alu_vec(32'h00000111, 5'd1));
    @(negedge clk);
    check("stall_ready_1", 32'(in_ready), 32'd1);
    drive(alu_vec(32'h00000222, 5'd2));
    @(negedge clk);
    drive(alu_vec(32'h00000333, 5'd3));
    check("stall_full_ready", 32'(in_ready), 32'd0);
    check("stall_full_count", 32'(wb_count), 32'd2);
    check("stall_head_wr", 32'(wb_reg_write), 32'd1);
    check("stall_head_data", wb_write_data, 32'h00000111);
    check("stall_head_reg", 32'(wb_write_reg), 32'd1);
    @(negedge clk);
    check("stall_hold_count", 32'(wb_count), 32'd2);
    check("stall_hold_data", wb_write_data, 32'h00000111);
    check("stall_hold_reg", 32'(wb_write_reg), 32'd1);
    check("stall_no_retire", 32'(wb_retire), 32'd0);
    wb_write_ready = 1'b1;
    @(negedge clk);
    check("drain1_data", wb_write_data, 32'h00000222);
    check("drain1_reg", 32'(wb_write_reg), 32'd2);
    check("drain1_count", 32'(wb_count), 32'd1);
    check("drain1_retire", 32'(wb_retire), 32'd1);
    check("drain1_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("drain2_data", wb_write_data, 32'h00000333);
    check("drain2_reg", 32'(wb_write_reg), 32'd3);
    check("drain2_count", 32'(wb_count), 32'd1);
    check("drain2_retire", 32'(wb_retire), 32'd1);
    @(negedge clk);
    check("drain3_count", 32'(wb_count), 32'd0);
    check("drain3_wr", 32'(wb_reg_write), 32'd0);
    check("drain3_retire", 32'(wb_retire), 32'd1);
    check("drain3_hold_data", wb_write_data, 32'h00000333);
    check("drain3_hold_reg", 32'(wb_write_reg), 32'd3);
    @(negedge clk);

    // Streaming: one push per cycle, one write per cycle
    drive(alu_vec(32'h10000000, 5'd1));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("stream%0d_data", k), wb_write_data, 32'h10000000 + 32'(k - 1));
      check($sformatf("stream%0d_reg", k), 32'(wb_write_reg), 32'(k));
      check($sformatf("stream%0d_wr", k), 32'(wb_reg_write), 32'd1);
      check($sformatf("stream%0d_count", k), 32'(wb_count), 32'd1);
      check($sformatf("stream%0d_ready", k), 32'(in_ready), 32'd1);
      check($sformatf("stream%0d_retire", k), 32'(wb_retire), (k >= 2) ? 32'd1 : 32'd0);
      if (k < 6) drive(alu_vec(32'h10000000 + 32'(k), 5'(k + 1)));
      else in_valid = 1'b0;
    end
    @(negedge clk);
    check("stream_end_count", 32'(wb_count), 32'd0);
    check("stream_end_retire", 32'(wb_retire), 32'd1);
    @(negedge clk);

    // Reset asserted while a write is stalled with the FIFO full
    wb_write_ready = 1'b0;
    drive(alu_vec(32'h0000AAAA, 5'd20));
    @(negedge clk);
    drive(alu_vec(32'h0000BBBB, 5'd21));
    @(negedge clk);
    in_valid = 1'b0;
    check("prerst_count", 32'(wb_count), 32'd2);
    check("prerst_wr", 32'(wb_reg_write), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_wr", 32'(wb_reg_write), 32'd0);
    check("midrst_count", 32'(wb_count), 32'd0);
    check("midrst_data", wb_write_data, 32'h0);
`ifdef WB_RETIRE_CNT_EN
    check("midrst_retire_cnt", 32'(wb_retire_cnt), 32'd0);
`endif
    wb_write_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("postrst%0d_wr", j), 32'(wb_reg_write), 32'd0);
      check($sformatf("postrst%0d_count", j), 32'(wb_count), 32'd0);
      check($sformatf("postrst%0d_retire", j), 32'(wb_retire), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
